// File: rtl/dmi_timeout_shim.sv
// Single-outstanding DMI stage between the DTM and the debug module. Each request is
// registered toward the DM. A DM that stays silent too long gets a synthetic FAILED response.
module dmi_timeout_shim #(
    parameter int ADDR_BITS      = 7,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_BITS       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_dtm_req_valid,
    output logic                 o_dtm_req_ready,
    input  logic [ADDR_BITS-1:0] i_dtm_req_addr,
    input  logic [1:0]           i_dtm_req_op,
    input  logic [31:0]          i_dtm_req_data,
    output logic                 o_dtm_resp_valid,
    input  logic                 i_dtm_resp_ready,
    output logic [1:0]           o_dtm_resp_resp,
    output logic [31:0]          o_dtm_resp_data,
    output logic                 o_dm_req_valid,
    input  logic                 i_dm_req_ready,
    output logic [ADDR_BITS-1:0] o_dm_req_addr,
    output logic [1:0]           o_dm_req_op,
    output logic [31:0]          o_dm_req_data,
    input  logic                 i_dm_resp_valid,
    output logic                 o_dm_resp_ready,
    input  logic [1:0]           i_dm_resp_resp,
    input  logic [31:0]          i_dm_resp_data,
    output logic                 o_busy,
    output logic [CNT_BITS-1:0]  o_timeout_count
);
    localparam int WB = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state, w_state_next;
    logic                  r_stale, w_stale_next;
    logic [WB-1:0]         r_wait_cnt, w_wait_cnt_next;
    logic [CNT_BITS-1:0]   r_timeout_count, w_timeout_count_next;
    logic                  r_dtm_req_ready, r_dm_resp_ready, r_busy;
    logic                  r_dm_req_valid, w_dm_req_valid_next;
    logic [ADDR_BITS-1:0]  r_dm_req_addr, w_dm_req_addr_next;
    logic [1:0]            r_dm_req_op, w_dm_req_op_next;
    logic [31:0]           r_dm_req_data, w_dm_req_data_next;
    logic                  r_dtm_resp_valid, w_dtm_resp_valid_next;
    logic [1:0]            r_dtm_resp_resp, w_dtm_resp_resp_next;
    logic [31:0]           r_dtm_resp_data, w_dtm_resp_data_next;
    logic                  w_req_fire, w_dm_resp_fire;

    assign w_req_fire     = i_dtm_req_valid & r_dtm_req_ready;
    assign w_dm_resp_fire = i_dm_resp_valid & r_dm_resp_ready;

    always_comb begin
        w_state_next          = r_state;
        w_stale_next          = r_stale;
        w_wait_cnt_next       = r_wait_cnt;
        w_timeout_count_next  = r_timeout_count;
        w_dm_req_valid_next   = r_dm_req_valid;
        w_dm_req_addr_next    = r_dm_req_addr;
        w_dm_req_op_next      = r_dm_req_op;
        w_dm_req_data_next    = r_dm_req_data;
        w_dtm_resp_valid_next = r_dtm_resp_valid;
        w_dtm_resp_resp_next  = r_dtm_resp_resp;
        w_dtm_resp_data_next  = r_dtm_resp_data;

        // A late beat from a timed-out request is swallowed whatever state we are in.
        if (r_stale && w_dm_resp_fire) begin
            w_stale_next = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_req_fire) begin
                    if (r_stale) begin
                        w_dtm_resp_valid_next = 1'b1;
                        w_dtm_resp_resp_next  = 2'd3;
                        w_dtm_resp_data_next  = 32'd0;
                        w_state_next          = S_RESP;
                    end else begin
                        w_dm_req_valid_next = 1'b1;
                        w_dm_req_addr_next  = i_dtm_req_addr;
                        w_dm_req_op_next    = i_dtm_req_op;
                        w_dm_req_data_next  = i_dtm_req_data;
                        w_state_next        = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (i_dm_req_ready) begin
                    w_dm_req_valid_next = 1'b0;
                    w_wait_cnt_next     = '0;
                    w_state_next        = S_WAIT;
                end
            end
            S_WAIT: begin
                w_wait_cnt_next = r_wait_cnt + 1'b1;
                if (w_dm_resp_fire) begin
                    w_dtm_resp_valid_next = 1'b1;
                    w_dtm_resp_resp_next  = i_dm_resp_resp;
                    w_dtm_resp_data_next  = i_dm_resp_data;
                    w_state_next          = S_RESP;
                end else if (TIMEOUT_CYCLES != 0 && r_wait_cnt == WB'(TIMEOUT_CYCLES - 1)) begin
                    w_dtm_resp_valid_next = 1'b1;
                    w_dtm_resp_resp_next  = 2'd2;
                    w_dtm_resp_data_next  = 32'd0;
                    w_stale_next          = 1'b1;
                    if (r_timeout_count != '1) begin
                        w_timeout_count_next = r_timeout_count + 1'b1;
                    end
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (i_dtm_resp_ready) begin
                    w_dtm_resp_valid_next = 1'b0;
                    w_state_next          = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_stale          <= 1'b0;
            r_wait_cnt       <= '0;
            r_timeout_count  <= '0;
            r_dtm_req_ready  <= 1'b0;
            r_dm_resp_ready  <= 1'b0;
            r_busy           <= 1'b0;
            r_dm_req_valid   <= 1'b0;
            r_dm_req_addr    <= '0;
            r_dm_req_op      <= 2'd0;
            r_dm_req_data    <= 32'd0;
            r_dtm_resp_valid <= 1'b0;
            r_dtm_resp_resp  <= 2'd0;
            r_dtm_resp_data  <= 32'd0;
        end else begin
            r_state          <= w_state_next;
            r_stale          <= w_stale_next;
            r_wait_cnt       <= w_wait_cnt_next;
            r_timeout_count  <= w_timeout_count_next;
            r_dtm_req_ready  <= (w_state_next == S_IDLE);
            r_dm_resp_ready  <= (w_state_next == S_WAIT) | w_stale_next;
            r_busy           <= (w_state_next != S_IDLE);
            r_dm_req_valid   <= w_dm_req_valid_next;
            r_dm_req_addr    <= w_dm_req_addr_next;
            r_dm_req_op      <= w_dm_req_op_next;
            r_dm_req_data    <= w_dm_req_data_next;
            r_dtm_resp_valid <= w_dtm_resp_valid_next;
            r_dtm_resp_resp  <= w_dtm_resp_resp_next;
            r_dtm_resp_data  <= w_dtm_resp_data_next;
        end
    end

    assign o_dtm_req_ready  = r_dtm_req_ready;
    assign o_dtm_resp_valid = r_dtm_resp_valid;
    assign o_dtm_resp_resp  = r_dtm_resp_resp;
    assign o_dtm_resp_data  = r_dtm_resp_data;
    assign o_dm_req_valid   = r_dm_req_valid;
    assign o_dm_req_addr    = r_dm_req_addr;
    assign o_dm_req_op      = r_dm_req_op;
    assign o_dm_req_data    = r_dm_req_data;
    assign o_dm_resp_ready  = r_dm_resp_ready;
    assign o_busy           = r_busy;
    assign o_timeout_count  = r_timeout_count;
endmodule

// File: tb/tb_dmi_timeout_shim.sv
// Randomised scoreboard bench for dmi_timeout_shim with a small transaction-level model
// of the DM timing, the stale/BUSY rule and the saturating timeout counter.
module tb_dmi_timeout_shim;
    localparam int AB     = 7;
    localparam int T      = 8;
    localparam int CB     = 2;
    localparam int TC_MAX = (1 << CB) - 1;
    localparam int BUDGET = 200;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_dtm_req_valid = 1'b0;
    logic          o_dtm_req_ready;
    logic [AB-1:0] i_dtm_req_addr = '0;
    logic [1:0]    i_dtm_req_op = 2'd0;
    logic [31:0]   i_dtm_req_data = 32'd0;
    logic          o_dtm_resp_valid;
    logic          i_dtm_resp_ready = 1'b0;
    logic [1:0]    o_dtm_resp_resp;
    logic [31:0]   o_dtm_resp_data;
    logic          o_dm_req_valid;
    logic          i_dm_req_ready = 1'b0;
    logic [AB-1:0] o_dm_req_addr;
    logic [1:0]    o_dm_req_op;
    logic [31:0]   o_dm_req_data;
    logic          i_dm_resp_valid = 1'b0;
    logic          o_dm_resp_ready;
    logic [1:0]    i_dm_resp_resp = 2'd0;
    logic [31:0]   i_dm_resp_data = 32'd0;
    logic          o_busy;
    logic [CB-1:0] o_timeout_count;

    dmi_timeout_shim #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(T), .CNT_BITS(CB)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_dtm_req_valid(i_dtm_req_valid), .o_dtm_req_ready(o_dtm_req_ready),
        .i_dtm_req_addr(i_dtm_req_addr), .i_dtm_req_op(i_dtm_req_op), .i_dtm_req_data(i_dtm_req_data),
        .o_dtm_resp_valid(o_dtm_resp_valid), .i_dtm_resp_ready(i_dtm_resp_ready),
        .o_dtm_resp_resp(o_dtm_resp_resp), .o_dtm_resp_data(o_dtm_resp_data),
        .o_dm_req_valid(o_dm_req_valid), .i_dm_req_ready(i_dm_req_ready),
        .o_dm_req_addr(o_dm_req_addr), .o_dm_req_op(o_dm_req_op), .o_dm_req_data(o_dm_req_data),
        .i_dm_resp_valid(i_dm_resp_valid), .o_dm_resp_ready(o_dm_resp_ready),
        .i_dm_resp_resp(i_dm_resp_resp), .i_dm_resp_data(i_dm_resp_data),
        .o_busy(o_busy), .o_timeout_count(o_timeout_count)
    );

    always #5 i_clk = ~i_clk;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t exp_q[$];
    logic [AB+33:0] dm_q[$];
    bit   m_stale = 1'b0;
    int   m_tc = 0;
    bit   drain_pending = 1'b0;
    int   txn_no = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {o_dtm_req_ready, o_dtm_resp_valid, o_dm_req_valid, o_dm_resp_ready, o_busy, o_timeout_count}, 0);
        chk({tag, "_resp"}, {o_dtm_resp_resp, o_dtm_resp_data}, 0);
        chk({tag, "_req"}, {o_dm_req_addr, o_dm_req_op, o_dm_req_data}, 0);
    endtask

    // DTM response backpressure, changed shortly after each rising edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #2 i_dtm_resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: sampled late in the cycle, so a valid&ready seen here completes on the next edge.
    initial begin
        rsp_t e;
        logic [AB+33:0] d;
        bit   rv_hold, dv_hold;
        logic [33:0] rv_prev;
        logic [AB+33:0] dv_prev;
        rv_hold = 0; dv_hold = 0; rv_prev = '0; dv_prev = '0;
        forever begin
            @(posedge i_clk);
            #8;
            if (i_reset) begin
                rv_hold = 0;
                dv_hold = 0;
            end else begin
                if (rv_hold) begin
                    chk("resp_valid_held", o_dtm_resp_valid, 1);
                    chk("resp_fields_stable", {o_dtm_resp_resp, o_dtm_resp_data}, rv_prev);
                end
                if (dv_hold) begin
                    chk("dm_valid_held", o_dm_req_valid, 1);
                    chk("dm_fields_stable", {o_dm_req_addr, o_dm_req_op, o_dm_req_data}, dv_prev);
                end
                if (o_dtm_resp_valid && i_dtm_resp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_dtm_resp", {o_dtm_resp_resp, o_dtm_resp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dtm_resp", {o_dtm_resp_resp, o_dtm_resp_data}, e);
                    end
                end
                if (o_dm_req_valid && i_dm_req_ready) begin
                    if (dm_q.size() == 0) begin
                        chk("unexpected_dm_req", {o_dm_req_addr, o_dm_req_op, o_dm_req_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        d = dm_q.pop_front();
                        chk("dm_req", {o_dm_req_addr, o_dm_req_op, o_dm_req_data}, d);
                    end
                end
                rv_hold = o_dtm_resp_valid && !i_dtm_resp_ready;
                rv_prev = {o_dtm_resp_resp, o_dtm_resp_data};
                dv_hold = o_dm_req_valid && !i_dm_req_ready;
                dv_prev = {o_dm_req_addr, o_dm_req_op, o_dm_req_data};
            end
        end
    end

    task automatic drain_pulse();
        chk("drain_ready", o_dm_resp_ready, 1);
        i_dm_resp_valid = 1'b1;
        i_dm_resp_data  = $urandom;
        @(negedge i_clk);
        i_dm_resp_valid = 1'b0;
        m_stale = 1'b0;
        chk("stale_cleared", o_dm_resp_ready, 0);
    endtask

    // rsp_dly: WAIT cycle (0-based) on which the DM answers; >= T means it stays silent.
    // drain: after a timeout, 0 = leave stale, 1 = late beat now, 2 = late beat alongside next request.
    task automatic do_txn(input logic [AB-1:0] addr, input logic [1:0] op, input logic [31:0] data,
                          input int rdy_dly, input int rsp_dly, input logic [1:0] code,
                          input logic [31:0] rdata, input int drain);
        bit   busy_exp, saw_dm;
        int   n, vcnt;
        rsp_t e;
        busy_exp = m_stale;
        if (busy_exp) begin
            e.resp = 2'd3; e.data = 32'd0;
            if (drain_pending) m_stale = 1'b0;
        end else begin
            dm_q.push_back({addr, op, data});
            if (rsp_dly < T) begin
                e.resp = code; e.data = rdata;
            end else begin
                e.resp = 2'd2; e.data = 32'd0;
                m_stale = 1'b1;
                if (m_tc < TC_MAX) m_tc++;
            end
        end
        exp_q.push_back(e);

        @(negedge i_clk);
        i_dtm_req_valid = 1'b1;
        i_dtm_req_addr  = addr;
        i_dtm_req_op    = op;
        i_dtm_req_data  = data;
        n = 0;
        while (!o_dtm_req_ready && n < BUDGET) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= BUDGET) chk("req_accept_bound", 0, 1);
        if (drain_pending) begin
            chk("drain_sim_ready", o_dm_resp_ready, 1);
            i_dm_resp_valid = 1'b1;
            i_dm_resp_data  = $urandom;
        end
        @(negedge i_clk);
        i_dtm_req_valid = 1'b0;
        i_dm_resp_valid = 1'b0;
        drain_pending   = 1'b0;

        if (!busy_exp) begin
            vcnt = 0;
            n = 0;
            while (n < BUDGET) begin
                i_dm_req_ready = (n >= rdy_dly);
                if (o_dm_req_valid) vcnt++;
                if (o_dm_req_valid && i_dm_req_ready) break;
                @(negedge i_clk);
                n++;
            end
            if (n >= BUDGET) chk("dm_req_bound", 0, 1);
            @(negedge i_clk);
            i_dm_req_ready = 1'b0;
            chk("dm_valid_cycles", vcnt, rdy_dly + 1);
            if (rsp_dly < T) begin
                repeat (rsp_dly) @(negedge i_clk);
                chk("wait_resp_ready", o_dm_resp_ready, 1);
                i_dm_resp_valid = 1'b1;
                i_dm_resp_resp  = code;
                i_dm_resp_data  = rdata;
                @(negedge i_clk);
                i_dm_resp_valid = 1'b0;
            end
        end

        saw_dm = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin
            saw_dm |= o_dm_req_valid;
            @(negedge i_clk);
            n++;
        end
        if (n >= BUDGET) begin
            chk("dtm_resp_bound", 0, 1);
            exp_q.delete();
        end
        if (busy_exp) chk("busy_no_dm_access", saw_dm, 0);
        chk("idle_req_ready", o_dtm_req_ready, 1);
        chk("idle_busy", o_busy, 0);
        chk("timeout_count", o_timeout_count, m_tc);
        chk("stale_resp_ready", o_dm_resp_ready, m_stale);

        if (m_stale && drain == 1) drain_pulse();
        else if (m_stale && drain == 2) drain_pending = 1'b1;

        txn_no++;
        $display("txn %0d addr=%0h op=%0d rdy=%0d rsp=%0d -> resp=%0d data=%08h stale=%0d tc=%0d",
                 txn_no, addr, op, rdy_dly, rsp_dly, e.resp, e.data, m_stale, m_tc);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset_state");
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("ready_after_reset", o_dtm_req_ready, 1);

        // Directed cases.
        do_txn(7'h22, 2'd1, 32'h0, 0, 1, 2'd0, 32'hDEADBEEF, 0);
        do_txn(7'h10, 2'd2, 32'h1, 5, 0, 2'd0, 32'h0, 0);
        do_txn(7'h05, 2'd1, 32'h0, 0, T + 4, 2'd0, 32'h0, 0);
        do_txn(7'h06, 2'd1, 32'h0, 0, 0, 2'd0, 32'h0, 1);
        do_txn(7'h07, 2'd1, 32'h0, 1, 2, 2'd0, 32'hCAFE0001, 0);
        do_txn(7'h08, 2'd1, 32'h0, 0, T - 1, 2'd3, 32'h12345678, 0);
        do_txn(7'h09, 2'd0, 32'h0, 0, 0, 2'd2, 32'h0, 0);
        // Stale clear coinciding with the next request handshake still yields BUSY.
        do_txn(7'h0A, 2'd1, 32'h0, 0, T, 2'd0, 32'h0, 2);
        do_txn(7'h0B, 2'd1, 32'h0, 0, 0, 2'd0, 32'h0, 0);
        do_txn(7'h0C, 2'd1, 32'h0, 0, 0, 2'd0, 32'h55AA55AA, 0);
        // Push the narrow timeout counter past saturation.
        for (int i = 0; i < 4; i++) do_txn(7'h30, 2'd1, 32'h0, 0, T, 2'd0, 32'h0, 1);

        for (int i = 0; i < 200; i++) begin
            do_txn(AB'($urandom), 2'($urandom_range(0, 2)), $urandom,
                   $urandom_range(0, 4), $urandom_range(0, T + 2), 2'($urandom), $urandom,
                   $urandom_range(0, 2));
        end

        // Reset while waiting on the DM, with the DM answering during reset.
        if (m_stale) drain_pulse();
        if (drain_pending) drain_pending = 1'b0;
        @(negedge i_clk);
        i_dtm_req_valid = 1'b1;
        i_dtm_req_addr  = 7'h11;
        i_dtm_req_op    = 2'd1;
        n = 0;
        while (!o_dtm_req_ready && n < BUDGET) begin @(negedge i_clk); n++; end
        dm_q.push_back({7'h11, 2'd1, i_dtm_req_data});
        @(negedge i_clk);
        i_dtm_req_valid = 1'b0;
        i_dm_req_ready  = 1'b1;
        @(negedge i_clk);
        i_dm_req_ready  = 1'b0;
        @(negedge i_clk);
        i_reset         = 1'b1;
        i_dm_resp_valid = 1'b1;
        i_dm_resp_data  = 32'h0BADF00D;
        @(negedge i_clk);
        check_all_zero("reset_in_wait");
        @(negedge i_clk);
        i_reset         = 1'b0;
        i_dm_resp_valid = 1'b0;
        exp_q.delete();
        dm_q.delete();
        m_stale = 1'b0;
        m_tc    = 0;
        @(negedge i_clk);
        chk("ready_after_abort", o_dtm_req_ready, 1);
        n = 0;
        repeat (4) begin
            if (o_dtm_resp_valid) n++;
            @(negedge i_clk);
        end
        chk("no_spurious_resp", n, 0);
        do_txn(7'h12, 2'd1, 32'h0, 0, 0, 2'd0, 32'hFEEDFACE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
